row_sequencer: RTL and testbench
================================

ROW_SEQUENCER -- requirements
Module: row_sequencer

Interface
REQ-001 Parameters: M=786 (rows per frame); N=786 (PE dot-product length); DW=16 (data width); SHIFT=8 (requant right shift, 0..2*DW-2); DEPTH=4 (output FIFO entries, power of 2).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a frame of M rows.
REQ-005 pe_valid  output  1  one-cycle pulse to the PE that starts one row.
REQ-006 row_idx  output  $clog2(M)  current row index selecting the PE row_data; held stable from pe_valid until pe_done.
REQ-007 pe_y  input  2*DW signed  PE dot-product result.
REQ-008 pe_done  input  1  PE result-valid pulse.
REQ-009 out_data  output  DW signed  requantized row result.
REQ-010 out_valid / out_ready  output / input  1 / 1  output stream handshake.
REQ-011 out_last  output  1  high with out_data of row M-1.
REQ-012 busy  output  1  high from the cycle after start is accepted until frame_done.
REQ-013 frame_done  output  1  one-cycle pulse when the last row result leaves the FIFO.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DRAIN.
REQ-015 IDLE: start=1 -> row_idx<=0, ISSUE; start in any other state is ignored.
REQ-016 ISSUE: if FIFO count < DEPTH, drive pe_valid=1 for exactly one cycle -> WAIT; otherwise hold in ISSUE with pe_valid=0.
REQ-017 WAIT: pe_done is ignored except in WAIT; on pe_done=1 capture requant(pe_y) into the FIFO tagged last=(row_idx==M-1); if row_idx<M-1, row_idx++ and -> ISSUE, else -> DRAIN.
REQ-018 DRAIN: when the FIFO becomes empty by pop of the last-tagged entry, pulse frame_done and -> IDLE.
REQ-019 Nominal PE latency: pe_done arrives N cycles after the pe_valid edge; the sequencer imposes no timeout.
REQ-020 Requant: sum = pe_y + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in 2*DW+1 bits; r = sum >>> SHIFT (arithmetic); saturate r to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 FIFO: first-word-fall-through; out_valid = not empty; pop when out_valid && out_ready; out_data/out_last show the head entry.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; push into a full FIFO cannot occur (guaranteed by REQ-016, checked by assertion).
REQ-023 Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-024 out_ready=0 indefinitely: at most DEPTH results are buffered, then the sequencer stalls in ISSUE; no data is lost or duplicated.
REQ-025 pe_done in IDLE, ISSUE or DRAIN (for example, the PE free-running after reset) produces no push.

Reset
REQ-026 On rst: state=IDLE, row_idx=0, pe_valid=0, busy=0, frame_done=0, FIFO emptied (out_valid=0, out_data=0, out_last=0).
REQ-027 Reset mid-frame aborts the frame immediately, discards buffered results, and emits no frame_done.

Structure
REQ-028 Package gemv_pkg SHALL hold the FSM state enum, the default DW/N/M constants and a requant function shared with other stages.
REQ-029 The FIFO SHALL be the sub-module sync_fifo (DEPTH, width DW+1); the FSM and requant logic stay in row_sequencer.

Verification (M=3, N=4, DW=16, SHIFT=8, DEPTH=4 unless stated)
REQ-030 Single frame, out_ready=1, PE model with 4-cycle latency, pe_y={0x00012345, 0x00000100, 0}: required out_data={291, 1, 0}; out_last only on the third result; frame_done 1 cycle after the third pop.
REQ-031 Saturation and rounding, pe_y={0x7FFFFFFF, 0x80000000, -384}: required out_data={32767, -32768, -1}.
REQ-032 Backpressure, M=6, out_ready=0 until 60 cycles: required 4 results buffered, sequencer held in ISSUE with no pe_valid; after release, all 6 results arrive in order with no gap caused by the sequencer.
REQ-033 Spurious pe_done pulses in IDLE and DRAIN, plus start pulsed during busy: required no extra FIFO entries and no frame restart.
REQ-034 rst asserted in WAIT of row 1 with 1 entry buffered: required all outputs at reset values in the same cycle, no frame_done; a new start then completes a full frame normally.

Source files
------------

// File: rtl/gemv_pkg.sv
// Types, default sizes and the requantization rule shared by the GEMV pipeline stages.
package gemv_pkg;

  localparam int unsigned DefaultDw    = 16;
  localparam int unsigned DefaultN     = 786;
  localparam int unsigned DefaultM     = 786;
  localparam int unsigned DefaultShift = 8;
  localparam int unsigned DefaultDepth = 4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} seq_state_e;

  // Round half up, arithmetic right shift, clamp to a dw-bit signed range.
  // The 64-bit working width covers 2*dw+1 bits for dw <= 31.
  function automatic logic signed [63:0] requant(logic signed [63:0] y, int unsigned shift,
                                                 int unsigned dw);
    logic signed [63:0] sum, r, hi, lo;
    sum = y;
    if (shift > 0) sum = sum + (64'sd1 <<< (shift - 1));
    r  = sum >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; the head entry is visible whenever the FIFO is not empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assert property (@(posedge clk) disable iff (rst) push |-> !full);

endmodule

// File: rtl/row_sequencer.sv
// Row sequencer: starts one PE dot-product per row, requantizes each result and
// streams it out through an FWFT FIFO, stalling issue while the FIFO is full.
module row_sequencer
  import gemv_pkg::*;
#(
  parameter int unsigned M     = DefaultM,
  parameter int unsigned N     = DefaultN,
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned SHIFT = DefaultShift,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned RowW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   pe_valid,
  output logic [RowW-1:0]        row_idx,
  input  logic signed [2*DW-1:0] pe_y,
  input  logic                   pe_done,
  output logic signed [DW-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [RowW-1:0] LastRow = RowW'(M - 1);

  seq_state_e      state_q, state_d;
  logic [RowW-1:0] row_d;
  logic            frame_done_d;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW:0]     fifo_wdata, fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_idx    <= row_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_idx;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!fifo_full) state_d = StWait;
      end
      StWait: begin
        if (pe_done) begin
          if (row_idx == LastRow) begin
            state_d = StDrain;
          end else begin
            row_d   = row_idx + RowW'(1);
            state_d = StIssue;
          end
        end
      end
      StDrain: begin
        // The last-tagged entry is the final push of the frame, so popping it empties the FIFO.
        if (fifo_pop && out_last) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pe_valid  = (state_q == StIssue) && !fifo_full;
    busy      = (state_q != StIdle);
    fifo_push = (state_q == StWait) && pe_done;
  end

  assign fifo_wdata = {row_idx == LastRow, DW'(requant(64'(pe_y), SHIFT, DW))};
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;
  assign {out_last, out_data} = fifo_rdata;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DW + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // N only characterises the PE; the sequencer waits on pe_done with no timeout.
  assert property (@(posedge clk) (N > 0) && (M > 0) && (DW <= 31) && (SHIFT <= 2 * DW - 2));

endmodule

// File: tb/tb_row_sequencer.sv
// Bench for row_sequencer: a 3-row instance for function/reset checks and a 6-row
// instance for backpressure, both checked against a queue-based reference model.
module tb_row_sequencer;

  localparam int unsigned DW    = 16;
  localparam int unsigned SHIFT = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NLAT  = 4;
  localparam int unsigned MA    = 3;
  localparam int unsigned MB    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start_a, pe_valid_a, pe_done_a, mdone_a, spur_a;
  logic               out_valid_a, out_ready_a, out_last_a, busy_a, frame_done_a;
  logic [1:0]         row_idx_a;
  logic signed [31:0] pe_y_a;
  logic signed [15:0] out_data_a;
  assign pe_done_a = mdone_a | spur_a;

  logic               start_b, pe_valid_b, pe_done_b;
  logic               out_valid_b, out_ready_b, out_last_b, busy_b, frame_done_b;
  logic [2:0]         row_idx_b;
  logic signed [31:0] pe_y_b;
  logic signed [15:0] out_data_b;

  row_sequencer #(.M(MA), .N(NLAT), .DW(DW), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pe_valid(pe_valid_a), .row_idx(row_idx_a),
    .pe_y(pe_y_a), .pe_done(pe_done_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_last(out_last_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  row_sequencer #(.M(MB), .N(NLAT), .DW(DW), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pe_valid(pe_valid_b), .row_idx(row_idx_b),
    .pe_y(pe_y_b), .pe_done(pe_done_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_last(out_last_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] expd);
    vectors++;
    assert (obs === expd) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expd);
    end
  endtask

  // Reference requantization: round half up, floor division, clamp to DW bits.
  function automatic int ref_requant(int y);
    longint d, s, q, hi, lo;
    d  = longint'(1) << SHIFT;
    s  = longint'(y) + ((SHIFT > 0) ? d / 2 : 0);
    q  = (s >= 0) ? s / d : -((-s + d - 1) / d);
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (q > hi) q = hi;
    else if (q < lo) q = lo;
    return int'(q);
  endfunction

  function automatic int rand_y();
    case ($urandom_range(0, 3))
      0: return int'($urandom);
      1: return int'($urandom_range(0, 140000)) - 70000;
      2: return (int'($urandom_range(0, 255)) - 128) * 256 + 128;
      default: return ($urandom_range(0, 1) != 0) ? 32'sh7FFFFFFF : 32'sh80000000;
    endcase
  endfunction

  int tab_a [MA];
  int tab_b [MB];
  int exp_d_a[$], exp_d_b[$], xcyc_b[$];
  bit exp_l_a[$], exp_l_b[$];
  int issued_a = 0, issued_b = 0, frames_a = 0, frames_b = 0, cyc = 0;
  bit lp_a = 0, lp_b = 0, rand_ready_a = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rand_ready_a) begin
    #1 out_ready_a = ($urandom_range(0, 1) != 0);
  end

  // PE models: result appears NLAT cycles after the pe_valid edge.
  initial forever begin : pe_model_a
    int idx;
    @(negedge clk);
    if (pe_valid_a) begin
      idx = int'(row_idx_a);
      issued_a++;
      repeat (NLAT) @(posedge clk);
      #1;
      if (busy_a) check("row_idx_hold_a", row_idx_a, idx);
      pe_y_a  = tab_a[idx];
      mdone_a = 1'b1;
      @(posedge clk);
      #1 mdone_a = 1'b0;
    end
  end

  initial forever begin : pe_model_b
    int idx;
    @(negedge clk);
    if (pe_valid_b) begin
      idx = int'(row_idx_b);
      issued_b++;
      repeat (NLAT) @(posedge clk);
      #1;
      if (busy_b) check("row_idx_hold_b", row_idx_b, idx);
      pe_y_b    = tab_b[idx];
      pe_done_b = 1'b1;
      @(posedge clk);
      #1 pe_done_b = 1'b0;
    end
  end

  // Output monitors: compare every transfer against the expected queue and require
  // frame_done exactly one cycle after the last-tagged transfer.
  always @(negedge clk) begin
    if (rst) lp_a = 1'b0;
    else begin
      if (frame_done_a || lp_a) check("frame_done_a", frame_done_a, lp_a);
      if (frame_done_a) frames_a++;
      lp_a = 1'b0;
      if (out_valid_a && out_ready_a) begin
        if (exp_d_a.size() == 0) check("extra_out_a", out_valid_a, 0);
        else begin
          check("out_data_a", out_data_a, exp_d_a.pop_front());
          lp_a = exp_l_a.pop_front();
          check("out_last_a", out_last_a, lp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) lp_b = 1'b0;
    else begin
      if (frame_done_b || lp_b) check("frame_done_b", frame_done_b, lp_b);
      if (frame_done_b) frames_b++;
      lp_b = 1'b0;
      if (out_valid_b && out_ready_b) begin
        xcyc_b.push_back(cyc);
        if (exp_d_b.size() == 0) check("extra_out_b", out_valid_b, 0);
        else begin
          check("out_data_b", out_data_b, exp_d_b.pop_front());
          lp_b = exp_l_b.pop_front();
          check("out_last_b", out_last_b, lp_b);
        end
      end
    end
  end

  task automatic pulse_start(bit sel_b);
    @(posedge clk);
    #1;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_frames_a(int target, int budget);
    int n = 0;
    while (frames_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_count_a", frames_a, target);
  endtask

  task automatic wait_issued_a(int target, int budget);
    int n = 0;
    while (issued_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("issue_count_a", issued_a, target);
  endtask

  task automatic plan_frame(bit sel_b);
    for (int i = 0; i < int'(sel_b ? MB : MA); i++) begin
      if (sel_b) begin
        tab_b[i] = rand_y();
        exp_d_b.push_back(ref_requant(tab_b[i]));
        exp_l_b.push_back(i == MB - 1);
      end else begin
        tab_a[i] = rand_y();
        exp_d_a.push_back(ref_requant(tab_a[i]));
        exp_l_a.push_back(i == MA - 1);
      end
    end
  endtask

  task automatic check_reset_a(string tag);
    check({tag, "_pe_valid"}, pe_valid_a, 0);
    check({tag, "_row_idx"}, row_idx_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_frame_done"}, frame_done_a, 0);
    check({tag, "_out_valid"}, out_valid_a, 0);
    check({tag, "_out_data"}, out_data_a, 0);
    check({tag, "_out_last"}, out_last_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, rel;
    rst = 1'b1;
    start_a = 1'b0; mdone_a = 1'b0; spur_a = 1'b0; out_ready_a = 1'b0; pe_y_a = '0;
    start_b = 1'b0; pe_done_b = 1'b0; out_ready_b = 1'b0; pe_y_b = '0;
    #2;
    check_reset_a("por");
    check("por_busy_b", busy_b, 0);
    check("por_out_valid_b", out_valid_b, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Spurious pe_done while idle must not push.
    spur_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 spur_a = 1'b0;
    @(negedge clk);
    check("idle_spur_out_valid", out_valid_a, 0);
    check("idle_spur_busy", busy_a, 0);

    // Directed frame with known results.
    tab_a[0] = 32'h00012345; tab_a[1] = 32'h00000100; tab_a[2] = 0;
    exp_d_a = '{291, 1, 0};
    exp_l_a = '{1'b0, 1'b0, 1'b1};
    out_ready_a = 1'b1;
    pulse_start(1'b0);
    check("busy_after_start", busy_a, 1);
    wait_frames_a(1, 100);
    check("drained_f1", exp_d_a.size(), 0);
    check("idle_after_f1", busy_a, 0);

    // Saturation/rounding; spurious pe_done and start while draining.
    tab_a[0] = 32'h7FFFFFFF; tab_a[1] = 32'h80000000; tab_a[2] = -384;
    exp_d_a = '{32767, -32768, -1};
    exp_l_a = '{1'b0, 1'b0, 1'b1};
    out_ready_a = 1'b0;
    base = issued_a;
    pulse_start(1'b0);
    wait_issued_a(base + 3, 100);
    repeat (NLAT + 3) @(posedge clk);
    #1;
    check("drain_holding", out_valid_a, 1);
    spur_a = 1'b1; start_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 spur_a = 1'b0; start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("drain_no_reissue", issued_a, base + 3);
    out_ready_a = 1'b1;
    wait_frames_a(2, 100);
    check("drained_f2", exp_d_a.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    check("no_restart_busy", busy_a, 0);
    check("no_restart_out_valid", out_valid_a, 0);
    check("no_restart_issue", issued_a, base + 3);

    // Random frames with random backpressure.
    rand_ready_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      plan_frame(1'b0);
      pulse_start(1'b0);
      wait_frames_a(3 + f, 400);
      check("drained_rand", exp_d_a.size(), 0);
    end
    rand_ready_a = 1'b0;
    @(posedge clk);
    #2 out_ready_a = 1'b0;

    // Reset while waiting on row 1 with one result buffered.
    for (int i = 0; i < int'(MA); i++) tab_a[i] = rand_y();
    base = issued_a;
    pulse_start(1'b0);
    wait_issued_a(base + 2, 100);
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", out_valid_a, 1);
    check("pre_rst_row_idx", row_idx_a, 1);
    check("pre_rst_busy", busy_a, 1);
    rst = 1'b1;
    #1 check_reset_a("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready_a = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid_a, 0);
    check("post_rst_frames", frames_a, 5);
    plan_frame(1'b0);
    pulse_start(1'b0);
    wait_frames_a(6, 100);
    check("drained_after_rst", exp_d_a.size(), 0);

    // Backpressure on the 6-row instance.
    plan_frame(1'b1);
    pulse_start(1'b1);
    repeat (58) @(posedge clk);
    @(negedge clk);
    check("bp_issued", issued_b, 4);
    check("bp_pe_valid", pe_valid_b, 0);
    check("bp_row_idx", row_idx_b, 4);
    check("bp_busy", busy_b, 1);
    check("bp_out_valid", out_valid_b, 1);
    @(posedge clk);
    #1 out_ready_b = 1'b1;
    rel = cyc;
    for (int n = 0; n < 200 && frames_b < 1; n++) @(negedge clk);
    check("bp_frames", frames_b, 1);
    check("bp_count", xcyc_b.size(), 6);
    check("bp_first_pop", xcyc_b[0], rel);
    check("bp_burst", xcyc_b[3], rel + 3);
    check("bp_drained", exp_d_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
